hash_generator: RTL

HASH_GENERATOR -- requirements
Module: hash_generator

---
 rtl/types_pkg.sv | 24 ++
 rtl/galois_lfsr16.sv | 31 +++
 rtl/hash_generator.sv | 110 +++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared types and constants for the keystream hash generator.
// Optional feature macro used by this slice: HASH_GEN_SEED_LOAD_EN (runtime seed load).
package types_pkg;

  typedef enum logic [1:0] {
    H_GROUND = 2'd0,
    H_READY  = 2'd1,
    H_BUSY   = 2'd2
  } hash_generator_state_t;

  localparam logic [15:0] HASH_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] HASH_LFSR_TAPS    = 16'hB400;

  // One right-shifting Galois step: the bit leaving at [0] folds the taps back in.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? HASH_LFSR_TAPS : 16'h0000);
  endfunction

  // An all-zero state would lock the LFSR forever, so it is swapped for the default seed.
  function automatic logic [15:0] seed_sanitize(input logic [15:0] seed);
    seed_sanitize = (seed == 16'h0000) ? HASH_DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/galois_lfsr16.sv
// 16-bit Galois LFSR register with step enable and synchronous load.
// Load has priority over stepping; reset returns to the default seed.
module galois_lfsr16
  import types_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        step_en,
  input  logic        load_en,
  input  logic [15:0] load_value,
  output logic        out_bit
);

  logic [15:0] lfsr_r;

  // LFSR state register: load, step or hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lfsr_r <= HASH_DEFAULT_SEED;
    end else if (load_en) begin
      lfsr_r <= load_value;
    end else if (step_en) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign out_bit = lfsr_r[0];

endmodule

// File: rtl/hash_generator.sv
// Keystream byte generator: on request, shifts eight LFSR output bits into a
// byte (first bit lands in bit 7) and presents it with a one-cycle strobe.
// Optional feature: define HASH_GEN_SEED_LOAD_EN to add a runtime seed load port.
module hash_generator
  import types_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  request_byte_pulse_in,
`ifdef HASH_GEN_SEED_LOAD_EN
  input  logic [15:0]           seed_in,
  input  logic                  seed_load_pulse,
`endif
  output logic [7:0]            hash_byte,
  output logic                  hash_byte_pulse,
  output hash_generator_state_t hash_generator_state_out
);

  hash_generator_state_t state_r;
  logic [6:0]            acc_r;
  logic [2:0]            bit_cnt_r;
  logic [7:0]            hash_byte_r;
  logic                  pulse_r;

  logic                  seed_load_s;
  logic [15:0]           seed_value_s;
  logic                  step_en_s;
  logic                  lfsr_bit_s;

`ifdef HASH_GEN_SEED_LOAD_EN
  assign seed_load_s  = seed_load_pulse;
  assign seed_value_s = seed_sanitize(seed_in);
`else
  assign seed_load_s  = 1'b0;
  assign seed_value_s = HASH_DEFAULT_SEED;
`endif

  // The LFSR advances only while a byte is being built; a seed load preempts stepping.
  always_comb begin
    step_en_s = 1'b0;
    if ((state_r == H_BUSY) && !seed_load_s) begin
      step_en_s = 1'b1;
    end else begin
      step_en_s = 1'b0;
    end
  end

  galois_lfsr16 u_lfsr (
    .clk        (clk),
    .nrst       (nrst),
    .step_en    (step_en_s),
    .load_en    (seed_load_s),
    .load_value (seed_value_s),
    .out_bit    (lfsr_bit_s)
  );

  // Request FSM, bit accumulator and registered byte/strobe outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= H_GROUND;
      acc_r       <= 7'd0;
      bit_cnt_r   <= 3'd0;
      hash_byte_r <= 8'h00;
      pulse_r     <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      if (seed_load_s) begin
        // Seed load wins over everything, including a same-edge request.
        state_r   <= H_GROUND;
        acc_r     <= 7'd0;
        bit_cnt_r <= 3'd0;
      end else begin
        case (state_r)
          H_GROUND, H_READY: begin
            if (request_byte_pulse_in) begin
              state_r   <= H_BUSY;
              acc_r     <= 7'd0;
              bit_cnt_r <= 3'd0;
            end else begin
              state_r <= state_r;
            end
          end
          H_BUSY: begin
            // Requests here are dropped silently.
            acc_r     <= {acc_r[5:0], lfsr_bit_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              hash_byte_r <= {acc_r, lfsr_bit_s};
              pulse_r     <= 1'b1;
              state_r     <= H_READY;
              bit_cnt_r   <= 3'd0;
            end else begin
              state_r <= H_BUSY;
            end
          end
          default: begin
            state_r   <= H_GROUND;
            acc_r     <= 7'd0;
            bit_cnt_r <= 3'd0;
          end
        endcase
      end
    end
  end

  assign hash_byte                = hash_byte_r;
  assign hash_byte_pulse          = pulse_r;
  assign hash_generator_state_out = state_r;

endmodule
